// File: rtl/fp32_dot_pkg.sv
// rtl/fp32_dot_pkg.sv - shared FP32 constants, flag indices and helpers
// Purpose: constants and helper functions used by the FP32 multiply/add
//          cells, the adder tree and the dot-product/accumulate top.
//          Flag vectors are {exception, overflow, underflow}.
package fp32_dot_pkg;

  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  localparam int FLAG_EXC = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Round-to-nearest-even and pack. n holds the 23 fraction bits followed by
  // guard, round and a sticky bit; the hidden one is implied. Results beyond
  // the normal range saturate to infinity, results below it flush to zero.
  // Returns {flags, value}.
  function automatic logic [34:0] round_pack(input logic s,
                                             input logic signed [9:0] e,
                                             input logic [25:0] n);
    logic [23:0]        m;
    logic signed [9:0]  er;
    logic [2:0]         f;
    logic [31:0]        y;
    m  = {1'b0, n[25:3]} + 24'(n[2] & (n[1] | n[0] | n[3]));
    er = m[23] ? e + 10'sd1 : e;
    f  = 3'b000;
    if (er >= 10'sd255) begin
      y           = {s, 8'hFF, 23'h0};
      f[FLAG_OVF] = 1'b1;
    end else if (er <= 10'sd0) begin
      y           = {s, 31'h0};
      f[FLAG_UNF] = 1'b1;
    end else begin
      y = {s, er[7:0], m[22:0]};
    end
    return {f, y};
  endfunction

endpackage

// File: rtl/fp32_add.sv
// rtl/fp32_add.sv - combinational FP32 adder cell
// Purpose: y = a + b with round-to-nearest-even; subnormal inputs are
//          treated as zero, exact cancellation gives +0.
// Ports:   a, b   - FP32 operands
//          y      - FP32 sum
//          flags  - {exception (NaN produced), overflow, underflow}
module fp32_add
  import fp32_dot_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic [2:0]  flags
);

  logic [7:0]        ea, eb, ex, ey, d;
  logic [22:0]       fa, fb;
  logic              sa, sb, sx, sy, swap, found;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [26:0]       mx, my, my_sh, n;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] e;

  always_comb begin
    ea     = a[30:23];
    eb     = b[30:23];
    fa     = a[22:0];
    fb     = b[22:0];
    sa     = a[31];
    sb     = b[31];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == 23'h0);
    b_inf  = (eb == 8'hFF) && (fb == 23'h0);
    a_nan  = (ea == 8'hFF) && (fa != 23'h0);
    b_nan  = (eb == 8'hFF) && (fb != 23'h0);
    // Order operands so x has the larger magnitude; the result takes its sign.
    swap   = {eb, fb} > {ea, fa};
    ex     = swap ? eb : ea;
    ey     = swap ? ea : eb;
    sx     = swap ? sb : sa;
    sy     = swap ? sa : sb;
    mx     = {1'b1, (swap ? fb : fa), 3'b000};
    my     = {1'b1, (swap ? fa : fb), 3'b000};
    d      = ex - ey;
    // Alignment shift keeps every shifted-out bit as a sticky bit in bit 0.
    my_sh  = (my >> d) | {26'h0, |(my & ~({27{1'b1}} << d))};
    e      = $signed({2'b00, ex});
    sum    = '0;
    n      = '0;
    lz     = '0;
    found  = 1'b0;
    y      = POS_ZERO;
    flags  = 3'b000;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      y               = QNAN;
      flags[FLAG_EXC] = 1'b1;
    end else if (a_inf) begin
      y = a;
    end else if (b_inf) begin
      y = b;
    end else if (a_zero && b_zero) begin
      y = {sa & sb, 31'h0};
    end else if (a_zero) begin
      y = b;
    end else if (b_zero) begin
      y = a;
    end else begin
      if (sx == sy) begin
        sum = {1'b0, mx} + {1'b0, my_sh};
        if (sum[27]) begin
          n = {sum[27:2], sum[1] | sum[0]};
          e = e + 10'sd1;
        end else begin
          n = sum[26:0];
        end
      end else begin
        sum = {1'b0, mx} - {1'b0, my_sh};
        n   = sum[26:0];
        for (int i = 26; i >= 0; i--) begin
          if (!found && n[i]) begin
            lz    = 5'(26 - i);
            found = 1'b1;
          end
        end
        n = n << lz;
        e = e - $signed({5'b00000, lz});
      end
      if (n == 27'h0) begin
        y = POS_ZERO;
      end else begin
        {flags, y} = round_pack(sx, e, n[25:0]);
      end
    end
  end

endmodule

// File: rtl/fp32_adder_tree.sv
// rtl/fp32_adder_tree.sv - pipelined pairwise FP32 reduction tree
// Purpose: sums N FP32 lanes through log2(N) registered adder levels; valid,
//          acc, last and flags travel alongside the data.
// Ports:   clk, rst_n          - clock, async active-low reset
//          en                  - stage enable; all levels advance together
//          in_valid/acc/last   - sideband of the beat entering level 1
//          in_flags            - flags accumulated before the tree
//          in_data             - N packed FP32 lanes, lane i at [32i+31:32i]
//          out_valid/acc/last  - sideband leaving the last level
//          out_flags           - in_flags OR every adder flag of the beat
//          out_sum             - FP32 sum of all lanes
module fp32_adder_tree
  import fp32_dot_pkg::*;
#(
  parameter int N = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic          in_acc,
  input  logic          in_last,
  input  logic [2:0]    in_flags,
  input  logic [N*32-1:0] in_data,
  output logic          out_valid,
  output logic          out_acc,
  output logic          out_last,
  output logic [2:0]    out_flags,
  output logic [31:0]   out_sum
);

  localparam int K = clog2(N);

  // Heap layout: node 1 is the root, node i sums children 2i and 2i+1.
  // Children numbered N..2N-1 are the input lanes.
  logic [31:0] leaf [N];
  logic [31:0] sum [1:N-1];
  logic [2:0]  add_flags [1:N-1];
  logic [31:0] node_q [1:N-1];
  logic [31:0] node_d [1:N-1];

  logic [K:1]      vld_q, vld_d, acc_q, acc_d, last_q, last_d;
  logic [K:1][2:0] flg_q, flg_d, lvl_f;
  logic [K:0]      vld_chain, acc_chain, last_chain;
  logic [K:0][2:0] flg_chain;

  always_comb begin
    for (int i = 0; i < N; i++) leaf[i] = in_data[32*i +: 32];
  end

  for (genvar i = 1; i < N; i++) begin : g_node
    logic [31:0] ca, cb;
    if (2 * i >= N) begin : g_from_leaf
      assign ca = leaf[2*i - N];
      assign cb = leaf[2*i + 1 - N];
    end else begin : g_from_node
      assign ca = node_q[2*i];
      assign cb = node_q[2*i + 1];
    end
    fp32_add u_add (.a(ca), .b(cb), .y(sum[i]), .flags(add_flags[i]));
  end

  // Stage s registers nodes N>>s .. (N>>(s-1))-1; their adder flags join
  // the beat's flags at that stage.
  always_comb begin
    lvl_f = '0;
    for (int s = 1; s <= K; s++) begin
      for (int i = (N >> s); i < (N >> (s - 1)); i++) begin
        lvl_f[s] = lvl_f[s] | add_flags[i];
      end
    end
  end

  assign vld_chain  = {vld_q, in_valid};
  assign acc_chain  = {acc_q, in_acc};
  assign last_chain = {last_q, in_last};
  assign flg_chain  = {flg_q, in_flags};

  always_comb begin
    vld_d  = en ? vld_chain[K-1:0]  : vld_q;
    acc_d  = en ? acc_chain[K-1:0]  : acc_q;
    last_d = en ? last_chain[K-1:0] : last_q;
    for (int s = 1; s <= K; s++) begin
      flg_d[s] = en ? (flg_chain[s-1] | lvl_f[s]) : flg_q[s];
    end
    for (int i = 1; i < N; i++) begin
      node_d[i] = en ? sum[i] : node_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      acc_q  <= '0;
      last_q <= '0;
      flg_q  <= '0;
      for (int i = 1; i < N; i++) node_q[i] <= POS_ZERO;
    end else begin
      vld_q  <= vld_d;
      acc_q  <= acc_d;
      last_q <= last_d;
      flg_q  <= flg_d;
      for (int i = 1; i < N; i++) node_q[i] <= node_d[i];
    end
  end

  assign out_valid = vld_q[K];
  assign out_acc   = acc_q[K];
  assign out_last  = last_q[K];
  assign out_flags = flg_q[K];
  assign out_sum   = node_q[1];

endmodule

// File: rtl/fp32_mul.sv
// rtl/fp32_mul.sv - combinational FP32 multiplier cell
// Purpose: y = a * b with round-to-nearest-even; subnormal inputs are
//          treated as zero.
// Ports:   a, b   - FP32 operands
//          y      - FP32 product
//          flags  - {exception (NaN produced), overflow, underflow}
module fp32_mul
  import fp32_dot_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic [2:0]  flags
);

  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic              s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]       prod;
  logic [25:0]       n;
  logic signed [9:0] e;

  always_comb begin
    ea     = a[30:23];
    eb     = b[30:23];
    fa     = a[22:0];
    fb     = b[22:0];
    s      = a[31] ^ b[31];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == 23'h0);
    b_inf  = (eb == 8'hFF) && (fb == 23'h0);
    a_nan  = (ea == 8'hFF) && (fa != 23'h0);
    b_nan  = (eb == 8'hFF) && (fb != 23'h0);
    prod   = 48'({1'b1, fa}) * 48'({1'b1, fb});
    e      = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    n      = '0;
    y      = POS_ZERO;
    flags  = 3'b000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      y               = QNAN;
      flags[FLAG_EXC] = 1'b1;
    end else if (a_inf || b_inf) begin
      y = {s, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      y = {s, 31'h0};
    end else begin
      // Product of two 1.x mantissas lies in [1,4); renormalise the [2,4) case.
      if (prod[47]) begin
        n = {prod[46:22], |prod[21:0]};
        e = e + 10'sd1;
      end else begin
        n = {prod[45:21], |prod[20:0]};
      end
      {flags, y} = round_pack(s, e, n);
    end
  end

endmodule

// File: rtl/fp32_dot_accum_pipe.sv
// rtl/fp32_dot_accum_pipe.sv - pipelined FP32 dot product with group accumulate
// Purpose: per accepted beat computes sum(vec_a[i]*vec_b[i]); non-acc beats
//          are output directly, acc beats are summed into an accumulator that
//          is output and cleared on the group's last beat.
// Ports:   clk, rst_n            - clock, async active-low reset
//          in_valid/in_ready     - input handshake
//          vec_a, vec_b          - N packed FP32 lanes
//          acc_mode, in_last     - beat is part of a group / closes it
//          out_valid/out_ready   - output handshake
//          out_data, out_flags   - FP32 result and {exc, ovf, unf}
module fp32_dot_accum_pipe
  import fp32_dot_pkg::*;
#(
  parameter int N      = 16,
  parameter int ACC_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*32-1:0] vec_a,
  input  logic [N*32-1:0] vec_b,
  input  logic            acc_mode,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [2:0]      out_flags
);

  logic adv;

  logic [N*32-1:0]   prod;
  logic [N-1:0][2:0] mul_flags;
  logic [2:0]        mul_or;
  logic              acc_eff;

  logic            s0_vld_q, s0_vld_d, s0_acc_q, s0_acc_d, s0_last_q, s0_last_d;
  logic [2:0]      s0_flags_q, s0_flags_d;
  logic [N*32-1:0] s0_prod_q, s0_prod_d;

  logic        t_valid, t_acc, t_last;
  logic [2:0]  t_flags;
  logic [31:0] t_sum;

  logic [31:0] acc_sum;
  logic [2:0]  acc_add_flags, grp_flags;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d, acc_q, acc_d;
  logic [2:0]  out_flags_q, out_flags_d, acc_flags_q, acc_flags_d;

  // A held result freezes the whole pipe, so nothing in flight is lost.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  for (genvar i = 0; i < N; i++) begin : g_lane
    fp32_mul u_mul (
      .a     (vec_a[32*i +: 32]),
      .b     (vec_b[32*i +: 32]),
      .y     (prod[32*i +: 32]),
      .flags (mul_flags[i])
    );
  end

  always_comb begin
    mul_or = 3'b000;
    for (int i = 0; i < N; i++) mul_or = mul_or | mul_flags[i];
    acc_eff    = (ACC_EN != 0) && acc_mode;
    s0_vld_d   = adv ? in_valid            : s0_vld_q;
    s0_acc_d   = adv ? acc_eff             : s0_acc_q;
    s0_last_d  = adv ? (acc_eff && in_last) : s0_last_q;
    s0_flags_d = adv ? mul_or              : s0_flags_q;
    s0_prod_d  = adv ? prod                : s0_prod_q;
  end

  fp32_adder_tree #(.N(N)) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (adv),
    .in_valid  (s0_vld_q),
    .in_acc    (s0_acc_q),
    .in_last   (s0_last_q),
    .in_flags  (s0_flags_q),
    .in_data   (s0_prod_q),
    .out_valid (t_valid),
    .out_acc   (t_acc),
    .out_last  (t_last),
    .out_flags (t_flags),
    .out_sum   (t_sum)
  );

  fp32_add u_acc_add (.a(acc_q), .b(t_sum), .y(acc_sum), .flags(acc_add_flags));

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    acc_d       = acc_q;
    acc_flags_d = acc_flags_q;
    grp_flags   = acc_flags_q | t_flags | acc_add_flags;
    if (adv) begin
      out_valid_d = 1'b0;
      if (t_valid) begin
        if (!t_acc) begin
          // Interleaved plain beats bypass the accumulator entirely.
          out_valid_d = 1'b1;
          out_data_d  = t_sum;
          out_flags_d = t_flags;
        end else if (t_last) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_sum;
          out_flags_d = grp_flags;
          acc_d       = POS_ZERO;
          acc_flags_d = 3'b000;
        end else begin
          acc_d       = acc_sum;
          acc_flags_d = grp_flags;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld_q    <= 1'b0;
      s0_acc_q    <= 1'b0;
      s0_last_q   <= 1'b0;
      s0_flags_q  <= 3'b000;
      s0_prod_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= POS_ZERO;
      out_flags_q <= 3'b000;
      acc_q       <= POS_ZERO;
      acc_flags_q <= 3'b000;
    end else begin
      s0_vld_q    <= s0_vld_d;
      s0_acc_q    <= s0_acc_d;
      s0_last_q   <= s0_last_d;
      s0_flags_q  <= s0_flags_d;
      s0_prod_q   <= s0_prod_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
      acc_q       <= acc_d;
      acc_flags_q <= acc_flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp32_dot_accum_pipe.sv
// tb/tb_fp32_dot_accum_pipe.sv - directed self-checking bench for fp32_dot_accum_pipe
module tb_fp32_dot_accum_pipe;

  localparam int N = 16;
  localparam int W = N * 32;

  localparam logic [31:0] F_ONE   = 32'h3F80_0000;
  localparam logic [31:0] F_TWO   = 32'h4000_0000;
  localparam logic [31:0] F_THREE = 32'h4040_0000;
  localparam logic [31:0] F_32    = 32'h4200_0000;
  localparam logic [31:0] F_48    = 32'h4240_0000;
  localparam logic [31:0] F_96    = 32'h42C0_0000;
  localparam logic [31:0] F_1P5   = 32'h3FC0_0000;
  localparam logic [31:0] F_2P25  = 32'h4010_0000;
  localparam logic [31:0] F_INF   = 32'h7F80_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  vec_a;
  logic [W-1:0]  vec_b;
  logic          acc_mode;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [2:0]    out_flags;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_data [$];
  logic [2:0]  q_flags [$];

  always #5 clk = ~clk;

  fp32_dot_accum_pipe #(.N(N), .ACC_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vec_a     (vec_a),
    .vec_b     (vec_b),
    .acc_mode  (acc_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  // Results are recorded once per handshake, mid-way between clock edges.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_flags.push_back(out_flags);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] fill(input logic [31:0] x);
    return {N{x}};
  endfunction

  function automatic logic [W-1:0] lane0(input logic [31:0] x);
    logic [W-1:0] v;
    v = '0;
    v[31:0] = x;
    return v;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic acc, input logic last);
    bit done;
    done     = 1'b0;
    vec_a    = a;
    vec_b    = b;
    acc_mode = acc;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (in_ready) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept: in_ready=%0b expected 1 within 60 cycles", in_ready);
    end
  endtask

  task automatic wait_outs(input int n);
    for (int i = 0; i < 60 && q_data.size() < n; i++) @(negedge clk);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vec_a     = '0;
    vec_b     = '0;
    acc_mode  = 1'b0;
    in_last   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %08h expected 00000000", out_data); end
    checks++;
    if (out_flags !== 3'b000) begin errors++; $display("FAIL reset_out_flags: got %03b expected 000", out_flags); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_latency;
    int lat;
    q_data.delete();
    q_flags.delete();
    send(fill(F_ONE), fill(F_TWO), 1'b0, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 6) begin errors++; $display("FAIL latency: got %0d cycles expected 6", lat); end
    checks++;
    if (out_data !== F_32) begin errors++; $display("FAIL latency_data: got %08h expected %08h", out_data, F_32); end
    checks++;
    if (out_flags !== 3'b000) begin errors++; $display("FAIL latency_flags: got %03b expected 000", out_flags); end
    wait_outs(1);
    checks++;
    if (q_data.size() != 1) begin errors++; $display("FAIL latency_count: got %0d results expected 1", q_data.size()); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic [31:0]  ed [5];
    logic [2:0]   ef [5];
    va[0] = fill(F_ONE);         vb[0] = fill(F_THREE);      ed[0] = F_48;         ef[0] = 3'b000;
    va[1] = fill(F_ONE);         vb[1] = '0;                 ed[1] = 32'h0;        ef[1] = 3'b000;
    for (int i = 0; i < N; i++) vb[1][32*i +: 32] = (i % 2 == 1) ? 32'hC000_0000 : F_TWO;
    va[2] = lane0(F_1P5);        vb[2] = lane0(F_1P5);       ed[2] = F_2P25;       ef[2] = 3'b000;
    va[3] = lane0(32'h7FC0_0000); vb[3] = lane0(F_ONE);      ed[3] = 32'h7FC0_0000; ef[3] = 3'b100;
    va[4] = lane0(32'h0080_0000); vb[4] = lane0(32'h0080_0000); ed[4] = 32'h0;     ef[4] = 3'b001;
    q_data.delete();
    q_flags.delete();
    for (int i = 0; i < 5; i++) send(va[i], vb[i], 1'b0, 1'b0);
    wait_outs(5);
    checks++;
    if (q_data.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d results expected 5", q_data.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < q_data.size()) begin
        checks++;
        if (q_data[i] !== ed[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %08h expected %08h", i, q_data[i], ed[i]); end
        checks++;
        if (q_flags[i] !== ef[i]) begin errors++; $display("FAIL b2b_flags[%0d]: got %03b expected %03b", i, q_flags[i], ef[i]); end
      end
    end
  endtask

  task automatic test_accumulate;
    q_data.delete();
    q_flags.delete();
    send(fill(F_ONE), fill(F_TWO), 1'b1, 1'b0);
    send(fill(F_ONE), fill(F_TWO), 1'b1, 1'b0);
    send(fill(F_ONE), fill(F_TWO), 1'b1, 1'b1);
    wait_outs(1);
    checks++;
    if (q_data.size() != 1) begin errors++; $display("FAIL acc_count: got %0d results expected 1", q_data.size()); end
    if (q_data.size() > 0) begin
      checks++;
      if (q_data[0] !== F_96) begin errors++; $display("FAIL acc_data: got %08h expected %08h", q_data[0], F_96); end
      checks++;
      if (q_flags[0] !== 3'b000) begin errors++; $display("FAIL acc_flags: got %03b expected 000", q_flags[0]); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] ed [3];
    int          w;
    ed[0] = F_32; ed[1] = F_48; ed[2] = F_2P25;
    q_data.delete();
    q_flags.delete();
    out_ready = 1'b0;
    send(fill(F_ONE), fill(F_TWO), 1'b0, 1'b0);
    send(fill(F_ONE), fill(F_THREE), 1'b0, 1'b0);
    send(lane0(F_1P5), lane0(F_1P5), 1'b0, 1'b0);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b expected 1", c, out_valid); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %0b expected 0", c, in_ready); end
      checks++;
      if (out_data !== F_32) begin errors++; $display("FAIL stall_data[%0d]: got %08h expected %08h", c, out_data, F_32); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_outs(3);
    checks++;
    if (q_data.size() != 3) begin errors++; $display("FAIL stall_count: got %0d results expected 3", q_data.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < q_data.size()) begin
        checks++;
        if (q_data[i] !== ed[i]) begin errors++; $display("FAIL stall_order[%0d]: got %08h expected %08h", i, q_data[i], ed[i]); end
      end
    end
  endtask

  task automatic test_overflow;
    q_data.delete();
    q_flags.delete();
    send(lane0(32'h7F7F_FFFF), lane0(F_TWO), 1'b0, 1'b0);
    send(lane0(32'h7F7F_FFFF), lane0(F_TWO), 1'b1, 1'b0);
    send(fill(F_ONE), fill(F_TWO), 1'b1, 1'b0);
    send(fill(F_ONE), fill(F_TWO), 1'b1, 1'b1);
    wait_outs(2);
    checks++;
    if (q_data.size() != 2) begin errors++; $display("FAIL ovf_count: got %0d results expected 2", q_data.size()); end
    if (q_data.size() >= 2) begin
      checks++;
      if (q_data[0] !== F_INF) begin errors++; $display("FAIL ovf_single_data: got %08h expected %08h", q_data[0], F_INF); end
      checks++;
      if (q_flags[0] !== 3'b010) begin errors++; $display("FAIL ovf_single_flags: got %03b expected 010", q_flags[0]); end
      checks++;
      if (q_data[1] !== F_INF) begin errors++; $display("FAIL ovf_group_data: got %08h expected %08h", q_data[1], F_INF); end
      checks++;
      if (q_flags[1] !== 3'b010) begin errors++; $display("FAIL ovf_group_flags: got %03b expected 010", q_flags[1]); end
    end
  endtask

  task automatic test_reset_mid_group;
    q_data.delete();
    q_flags.delete();
    send(fill(F_ONE), fill(F_TWO), 1'b1, 1'b0);
    send(fill(F_ONE), fill(F_TWO), 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b expected 0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %0b expected 1", in_ready); end
    @(negedge clk);
    send(fill(F_ONE), fill(F_TWO), 1'b1, 1'b1);
    wait_outs(1);
    checks++;
    if (q_data.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d results expected 1", q_data.size()); end
    if (q_data.size() > 0) begin
      checks++;
      if (q_data[0] !== F_32) begin errors++; $display("FAIL midrst_data: got %08h expected %08h", q_data[0], F_32); end
      checks++;
      if (q_flags[0] !== 3'b000) begin errors++; $display("FAIL midrst_flags: got %03b expected 000", q_flags[0]); end
    end
  endtask

  task automatic test_interleave;
    q_data.delete();
    q_flags.delete();
    send(fill(F_ONE), fill(F_TWO), 1'b1, 1'b0);
    send(fill(F_ONE), fill(F_TWO), 1'b0, 1'b1);
    send(fill(F_ONE), fill(F_TWO), 1'b1, 1'b0);
    send(fill(F_ONE), fill(F_TWO), 1'b1, 1'b1);
    wait_outs(2);
    checks++;
    if (q_data.size() != 2) begin errors++; $display("FAIL ilv_count: got %0d results expected 2", q_data.size()); end
    if (q_data.size() >= 2) begin
      checks++;
      if (q_data[0] !== F_32) begin errors++; $display("FAIL ilv_single: got %08h expected %08h", q_data[0], F_32); end
      checks++;
      if (q_data[1] !== F_96) begin errors++; $display("FAIL ilv_group: got %08h expected %08h", q_data[1], F_96); end
      checks++;
      if (q_flags[1] !== 3'b000) begin errors++; $display("FAIL ilv_group_flags: got %03b expected 000", q_flags[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_accumulate();
    test_backpressure();
    test_overflow();
    test_reset_mid_group();
    test_interleave();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_dot_accum_pipe.md
FP32_DOT_ACCUM_PIPE -- requirements
Module: fp32_dot_accum_pipe

Interface
REQ-001 SHALL have parameter N, default 16: lane count, power of two, range 2..64.
REQ-002 SHALL have parameter ACC_EN, default 1: 1 builds the accumulate mode, 0 ties acc_mode off.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: beat valid.
REQ-006 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-007 SHALL have port vec_a, input, N*32: lane i at [32i+31:32i], FP32.
REQ-008 SHALL have port vec_b, input, N*32: same packing as vec_a.
REQ-009 SHALL have port acc_mode, input, 1: beat belongs to an accumulation group.
REQ-010 SHALL have port in_last, input, 1: final beat of the group; ignored when acc_mode=0.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port out_data, output, 32: FP32 dot product or accumulated sum.
REQ-014 SHALL have port out_flags, output, 3: {exception, overflow, underflow}, OR of all lanes and beats in the result.

Function
REQ-015 SHALL define pipeline stages as: S0 N lane multipliers registered; S1..SK pairwise adder levels, K=log2(N); SA accumulate stage. Latency L=K+2 cycles from accepted beat to out_valid; L=6 at N=16.
REQ-016 SHALL advance all stages together on adv = !out_valid || out_ready; in_ready = adv.
REQ-017 SHALL carry a valid bit, acc_mode, in_last and 3-bit flags with the data through every stage; bubbles SHALL NOT alter the accumulator.
REQ-018 SHALL, for a non-acc beat reaching SA, present the tree sum on out_data with out_valid=1; the accumulator SHALL be untouched.
REQ-019 SHALL, for an acc beat reaching SA, compute acc_next = acc + tree sum, with acc=+0.0 at group start.
REQ-020 SHALL, on a non-last acc beat, store acc_next and keep out_valid low.
REQ-021 SHALL, on a last acc beat, output acc_next, assert out_valid, reset acc to +0.0 and clear the sticky flags.
REQ-022 SHALL OR flags stickily across a group and report them with the group result.
REQ-023 SHALL allow a non-acc beat interleaved mid-group; it SHALL be output independently and SHALL leave acc and the sticky flags unchanged.
REQ-024 SHALL hold out_data and out_flags stable while out_valid && !out_ready.
REQ-025 SHALL use the team FP32 multiply/add rounding and special-value rules unchanged; no extra rounding.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear all stage valid bits, out_valid=0, out_data=32'h0, out_flags=0, acc=32'h0 and sticky flags=0.
REQ-027 SHALL discard any partial group on reset mid-operation; the first group after reset SHALL start from +0.0.
REQ-028 SHALL drive in_ready=1 in the first cycle after reset release.

Structure
REQ-029 SHALL place FP32 constants (POS_ZERO, flag bit indices) and a clog2 helper in shared package fp32_dot_pkg.
REQ-030 SHALL reuse the existing FP32 multiplier and FP32 adder cells.
REQ-031 SHALL implement the reduction as sub-module fp32_adder_tree, parametrised by N, registered per level, with a stage-enable input.

Verification
REQ-032 Scenario 1: N=16, all lanes 3F800000 x 40000000, acc_mode=0, out_ready=1 -> out_data=42000000 (32.0) exactly 6 cycles later, flags=000.
REQ-033 Scenario 2: three acc beats as in Scenario 1, last beat flagged -> one output 42C00000 (96.0); out_valid low for beats 1-2.
REQ-034 Scenario 3: out_ready held low 4 cycles with results in flight -> in_ready low, out_data stable, no result lost or duplicated; order preserved.
REQ-035 Scenario 4: lane0 7F7FFFFF x 40000000, other lanes zero -> overflow bit set in out_flags; in acc mode it remains set through to the last beat.
REQ-036 Scenario 5: rst_n pulsed low after beat 2 of an acc group, then a single-beat group of 32.0 -> out_data=42000000 with no residue.
REQ-037 Scenario 6: acc group interleaved with a non-acc beat -> non-acc result 42000000 emitted alone; group sum unaffected.
